text_line_sequencer: RTL
========================

// Module: text_line_sequencer
// PURPOSE
//   Streams the four 128-bit ASCII disassembly lines produced by the instruction
//   text decoder to a byte-wide character-display sink (HD44780-class LCD writer
//   or UART TX) over a valid/ready handshake.
//   Snapshots all four lines on a start pulse, then emits, per line, one
//   cursor-address command byte followed by 16 character bytes.
//   Sits between the instruction text decoder and the display/UART driver.
// PARAMETERS
//   PAD_CHAR      8'h20           substituted for any 8'h00 byte in a line
//   CMD_SET_ADDR  8'h80           OR-ed with the line DDRAM address to form the command byte
//   LINE_ADDRS    32'h00_40_10_50 DDRAM start addresses; line0 in [31:24] ... line3 in [7:0]
// PORTS
//   clk        in   1    system clock, all state on rising edge
//   rst        in   1    asynchronous, active-high reset
//   start      in   1    single-cycle request to capture line0..line3 and send them
//   line0      in   128  text line 0; first character in [127:120], last in [7:0]
//   line1      in   128  text line 1, same layout
//   line2      in   128  text line 2, same layout
//   line3      in   128  text line 3, same layout
//   out_ready  in   1    sink accepts out_data this cycle when out_valid=1
//   out_valid  out  1    out_data/out_is_cmd hold a byte to transfer
//   out_data   out  8    command or character byte
//   out_is_cmd out  1    1: out_data is a cursor command; 0: character data
//   busy       out  1    1 from the cycle after start capture until done
//   done       out  1    one-cycle pulse after the last byte of line3 is accepted
// BEHAVIOUR
//   Reset (asynchronous, any state): state=IDLE, out_valid=0, out_data=8'h00,
//     out_is_cmd=0, busy=0, done=0, line/char counters=0, pending=0, snapshot=0.
//   FSM: IDLE -> CMD -> CHAR -> (CMD | DONE) -> IDLE.
//   IDLE: on start=1 at edge N, capture line0..3 into the snapshot, go to CMD;
//     at cycle N+1: out_valid=1, out_is_cmd=1,
//     out_data=CMD_SET_ADDR|LINE_ADDRS[line], busy=1.
//   Transfer: occurs on the edge where out_valid&&out_ready.
//     While out_valid&&!out_ready, out_data and out_is_cmd are held stable.
//     out_valid never drops without a transfer.
//   CMD: on transfer, go to CHAR with char_idx=0.
//     The next byte is presented the following cycle, so back-to-back transfers
//     run at 1 byte/clock when out_ready is held high.
//   CHAR: out_data = snapshot[line][127-8*char_idx -: 8];
//     a 8'h00 byte is replaced by PAD_CHAR; out_is_cmd=0.
//     On transfer with char_idx<15: char_idx+1.
//     On transfer with char_idx=15: char_idx wraps to 0.
//       If line<3: line+1, go to CMD.
//       If line=3: go to DONE.
//   DONE: out_valid=0, done=1 for exactly one cycle, busy=0 in the same cycle,
//     then go to IDLE with line=0.
//   Total per frame: 68 transfers (4 x (1 cmd + 16 chars));
//     minimum frame latency is start edge to done = 69 cycles.
//   start while busy or in DONE: the snapshot is NOT updated; pending is set
//     (one-deep; further starts are merged).
//     On leaving DONE with pending=1: clear pending, capture the current line0..3,
//     go to CMD (no IDLE cycle).
//   start in the same cycle as the final transfer: counts as pending.
//   Input lines may change freely after the capture edge; the output reflects
//     only the snapshot.
//   Reset asserted mid-frame: the frame is abandoned immediately, with no done pulse.
//     The sink must tolerate a truncated stream.
// TESTING
//   1. start with line0=128'h41_44_44_00_52_31_00_2B_00_52_32_3A (upper 4 bytes 0), out_ready=1
//      -> first bytes 80(cmd), 20,20,20,20, 41,44,44,20,...,3A;
//      then C0(cmd) for line1; done at cycle 69.
//   2. out_ready toggling 1/0 every cycle
//      -> exactly 68 transfers, no byte duplicated or dropped;
//      out_data stable during every stall; done once.
//   3. Two back-to-back starts: second start at byte 10 with different lines
//      -> frame 1 completes with the original data; frame 2 begins with a
//      cmd byte 80 the cycle after done, carrying the new data.
//   4. rst asserted at transfer 30, released 3 cycles later
//      -> all outputs 0 immediately; no done pulse; the next start sends a full 68-byte frame.
//   5. All lines 128'h0
//      -> 64 char bytes all 8'h20, cmd bytes 80, C0, 90, D0 in order.
//   6. out_ready=0 held for 50 cycles after start
//      -> out_valid=1 with out_data=80 and out_is_cmd=1 stable for all 50 cycles; busy=1.

Source files
------------

// File: rtl/text_line_sequencer_if.sv
// Byte-stream handshake between the line sequencer (master) and a character sink.
//   out_valid  : master -> slave, byte present
//   out_ready  : slave -> master, byte accepted when out_valid=1
//   out_data   : master -> slave, command or character byte
//   out_is_cmd : master -> slave, 1 = cursor command, 0 = character
interface text_line_sequencer_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_is_cmd;

  modport master (output out_valid, output out_data, output out_is_cmd, input out_ready);
  modport slave  (input out_valid, input out_data, input out_is_cmd, output out_ready);
endinterface

// File: rtl/text_line_sequencer.sv
// Snapshots four 16-character text lines on start and streams them to a
// byte-wide display sink: per line, one cursor-address command then 16 chars.
//   clk, rst      : clock, asynchronous active-high reset
//   start_i       : capture line0_i..line3_i and send them (merged while busy)
//   line0_i..3_i  : 128-bit text lines, first character in [127:120]
//   out_if        : master side of the valid/ready byte stream
//   busy_o        : frame in progress
//   done_o        : one-cycle pulse after the last byte of line 3 is accepted
module text_line_sequencer #(
  parameter logic [7:0]  PAD_CHAR     = 8'h20,
  parameter logic [7:0]  CMD_SET_ADDR = 8'h80,
  parameter logic [31:0] LINE_ADDRS   = 32'h0040_1050
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [127:0]          line0_i,
  input  logic [127:0]          line1_i,
  input  logic [127:0]          line2_i,
  input  logic [127:0]          line3_i,
  text_line_sequencer_if.master out_if,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned LINE_W = 128;
  localparam int unsigned NLINES = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_CHAR = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]                    state_q, state_d;
  logic [1:0]                    line_q, line_d;
  logic [3:0]                    char_q, char_d;
  logic                          pending_q, pending_d;
  logic [NLINES-1:0][LINE_W-1:0] snap_q, snap_d;
  logic                          valid_q, valid_d;
  logic [7:0]                    data_q, data_d;
  logic                          is_cmd_q, is_cmd_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic [NLINES-1:0][LINE_W-1:0] lines_in;
  logic                          xfer;

  assign lines_in = {line3_i, line2_i, line1_i, line0_i};
  assign xfer     = valid_q && out_if.out_ready;

  // Character idx of a line; the LSB offset 8*(15-idx) equals {~idx,3'b000}.
  function automatic logic [7:0] char_byte(input logic [LINE_W-1:0] ln, input logic [3:0] idx);
    logic [7:0] b;
    b = ln[{~idx, 3'b000} +: 8];
    return (b == 8'h00) ? PAD_CHAR : b;
  endfunction

  // Cursor command for a line; line 0 address sits in the top byte.
  function automatic logic [7:0] cmd_byte(input logic [1:0] ln);
    return CMD_SET_ADDR | LINE_ADDRS[{~ln, 3'b000} +: 8];
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    char_d    = char_q;
    pending_d = pending_q;
    snap_d    = snap_q;
    valid_d   = valid_q;
    data_d    = data_q;
    is_cmd_d  = is_cmd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          snap_d   = lines_in;
          state_d  = S_CMD;
          line_d   = 2'd0;
          char_d   = 4'd0;
          valid_d  = 1'b1;
          is_cmd_d = 1'b1;
          data_d   = cmd_byte(2'd0);
          busy_d   = 1'b1;
        end
      end
      S_CMD: begin
        if (start_i) pending_d = 1'b1;
        if (xfer) begin
          state_d  = S_CHAR;
          char_d   = 4'd0;
          is_cmd_d = 1'b0;
          data_d   = char_byte(snap_q[line_q], 4'd0);
        end
      end
      S_CHAR: begin
        // A start coinciding with the final transfer is also held as pending
        if (start_i) pending_d = 1'b1;
        if (xfer) begin
          if (char_q != 4'd15) begin
            char_d = char_q + 4'd1;
            data_d = char_byte(snap_q[line_q], char_q + 4'd1);
          end else begin
            char_d = 4'd0;
            if (line_q != 2'd3) begin
              line_d   = line_q + 2'd1;
              state_d  = S_CMD;
              is_cmd_d = 1'b1;
              data_d   = cmd_byte(line_q + 2'd1);
            end else begin
              state_d = S_DONE;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        line_d = 2'd0;
        // A queued (or same-cycle) request restarts without an IDLE cycle
        if (pending_q || start_i) begin
          pending_d = 1'b0;
          snap_d    = lines_in;
          state_d   = S_CMD;
          valid_d   = 1'b1;
          is_cmd_d  = 1'b1;
          data_d    = cmd_byte(2'd0);
          busy_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      line_q    <= 2'd0;
      char_q    <= 4'd0;
      pending_q <= 1'b0;
      snap_q    <= '0;
      valid_q   <= 1'b0;
      data_q    <= 8'h00;
      is_cmd_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      char_q    <= char_d;
      pending_q <= pending_d;
      snap_q    <= snap_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      is_cmd_q  <= is_cmd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign out_if.out_valid  = valid_q;
  assign out_if.out_data   = data_q;
  assign out_if.out_is_cmd = is_cmd_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;

endmodule
